// File: rtl/pipe_ctrl_pkg.sv
// Shared CPU pipeline-control definitions: memory FSM encoding, default timeout
// and the source-operand match helper used by hazard detection.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_t;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;
  localparam int unsigned REG_IDX_W              = 5;
  localparam int unsigned NUM_SRC                = 2;

  function automatic logic src_match(
    input logic                 re,
    input logic [REG_IDX_W-1:0] rs,
    input logic [REG_IDX_W-1:0] rd
  );
    return re && (rs == rd);
  endfunction

endpackage

// File: rtl/pipe_ctrl_memfsm.sv
// Data-memory handshake FSM: holds the request through WAIT until ready or
// timeout, then spends one DONE cycle so the released pipeline can advance.
module pipe_ctrl_memfsm
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mem_req,
  input  logic dmem_ready,
  output logic dmem_req,
  output logic mem_stop,
  output logic err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  // The counter holds WAIT cycles already completed, so the last allowed
  // WAIT cycle is the one that sees TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_t       state_reg;
  logic [CNT_W-1:0] wait_cnt_reg;
  logic             dmem_req_reg;
  logic             err_reg;
  logic             timeout_hit;

  assign timeout_hit = (wait_cnt_reg == LAST_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= MEM_IDLE;
      wait_cnt_reg <= '0;
      dmem_req_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      case (state_reg)
        MEM_IDLE: begin
          if (mem_req) begin
            state_reg    <= MEM_WAIT;
            dmem_req_reg <= 1'b1;
            wait_cnt_reg <= '0;
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            state_reg    <= MEM_DONE;
            dmem_req_reg <= 1'b0;
            wait_cnt_reg <= '0;
          end else if (timeout_hit) begin
            state_reg    <= MEM_DONE;
            dmem_req_reg <= 1'b0;
            err_reg      <= 1'b1;
            wait_cnt_reg <= '0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
          end
        end
        MEM_DONE: begin
          state_reg    <= MEM_IDLE;
          dmem_req_reg <= 1'b0;
        end
        default: begin
          state_reg    <= MEM_IDLE;
          dmem_req_reg <= 1'b0;
          wait_cnt_reg <= '0;
        end
      endcase
    end
  end

  // The detect cycle must freeze before the state register has moved.
  assign mem_stop = (state_reg == MEM_WAIT) || ((state_reg == MEM_IDLE) && mem_req);
  assign dmem_req = dmem_req_reg;
  assign err      = err_reg;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: memory-stall freeze, branch flush and load-use
// stall with fixed priority, plus a free-running stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_rs1_re,
  input  logic                 id_rs2_re,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_wR,
  input  logic                 branch_taken_i,
  input  logic                 mem_req_i,
  input  logic                 dmem_ready_i,
  output logic                 dmem_req_o,
  output logic                 pipe_stop_o,
  output logic                 if_stop_o,
  output logic                 id_flush_o,
  output logic                 ex_flush_o,
  output logic                 err_o,
  output logic [31:0]          stall_cnt_o
);

  logic                              mem_stop;
  logic [NUM_SRC-1:0][REG_IDX_W-1:0] src_idx;
  logic [NUM_SRC-1:0]                src_re;
  logic [NUM_SRC-1:0]                src_hit;
  logic                              load_use;
  logic [31:0]                       stall_cnt_reg;

  pipe_ctrl_memfsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_memfsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_req   (mem_req_i),
    .dmem_ready(dmem_ready_i),
    .dmem_req  (dmem_req_o),
    .mem_stop  (mem_stop),
    .err       (err_o)
  );

  assign src_idx = {id_rs2, id_rs1};
  assign src_re  = {id_rs2_re, id_rs1_re};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign src_hit[gi] = src_match(src_re[gi], src_idx[gi], ex_wR);
    end
  endgenerate

  // x0 is hardwired, so a load targeting it never creates a dependency.
  assign load_use = ex_mem_read && (ex_wR != '0) && (|src_hit);

  always_comb begin
    pipe_stop_o = mem_stop;
    if_stop_o   = 1'b0;
    id_flush_o  = 1'b0;
    ex_flush_o  = 1'b0;
    if (mem_stop) begin
      if_stop_o = 1'b1;
    end else if (branch_taken_i) begin
      id_flush_o = 1'b1;
      ex_flush_o = 1'b1;
    end else if (load_use) begin
      if_stop_o  = 1'b1;
      ex_flush_o = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (if_stop_o || pipe_stop_o) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table for the hazard/priority
// logic plus hand sequences for memory stall, timeout and mid-WAIT reset.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_wR;
  logic        id_rs1_re, id_rs2_re, ex_mem_read;
  logic        branch_taken_i, mem_req_i, dmem_ready_i;
  logic        dmem_req_o, pipe_stop_o, if_stop_o, id_flush_o, ex_flush_o, err_o;
  logic [31:0] stall_cnt_o;

  pipe_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_re(id_rs1_re), .id_rs2_re(id_rs2_re),
    .ex_mem_read(ex_mem_read), .ex_wR(ex_wR), .branch_taken_i(branch_taken_i),
    .mem_req_i(mem_req_i), .dmem_ready_i(dmem_ready_i), .dmem_req_o(dmem_req_o),
    .pipe_stop_o(pipe_stop_o), .if_stop_o(if_stop_o), .id_flush_o(id_flush_o),
    .ex_flush_o(ex_flush_o), .err_o(err_o), .stall_cnt_o(stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp bits: {if_stop, id_flush, ex_flush, pipe_stop, dmem_req, err}
  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, wr;
    logic       re1, re2, mrd, br, mreq, rdy;
    logic [5:0] exp;
  } vec_t;

  vec_t        sb_q[$];
  vec_t        tbl[9];
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_cnt = 0;
  logic [31:0] base_cnt;

  function automatic vec_t mk(string nm, logic [4:0] rs1, logic re1, logic [4:0] rs2, logic re2,
                              logic mrd, logic [4:0] wr, logic br, logic mreq, logic rdy,
                              logic [5:0] exp);
    vec_t v;
    v.name = nm; v.rs1 = rs1; v.re1 = re1; v.rs2 = rs2; v.re2 = re2; v.mrd = mrd;
    v.wr = wr; v.br = br; v.mreq = mreq; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  task automatic drive(input vec_t v);
    id_rs1 = v.rs1; id_rs1_re = v.re1; id_rs2 = v.rs2; id_rs2_re = v.re2;
    ex_mem_read = v.mrd; ex_wR = v.wr; branch_taken_i = v.br;
    mem_req_i = v.mreq; dmem_ready_i = v.rdy;
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    @(posedge clk); #1;
    drive(v);
    sb_q.push_back(v);
    @(negedge clk);
    e = sb_q.pop_front();
    chk({e.name, " outs"}, {26'd0, if_stop_o, id_flush_o, ex_flush_o, pipe_stop_o, dmem_req_o, err_o},
        {26'd0, e.exp});
    chk({e.name, " stall_cnt"}, stall_cnt_o, exp_cnt);
    if (e.exp[5] || e.exp[2]) exp_cnt = exp_cnt + 32'd1;
  endtask

  initial begin
    tbl[0] = mk("lu_rs1",        5'd5, 1, 5'd0, 0, 1, 5'd5, 0, 0, 0, 6'b101000);
    tbl[1] = mk("lu_x0",         5'd0, 1, 5'd0, 0, 1, 5'd0, 0, 0, 0, 6'b000000);
    tbl[2] = mk("lu_rs2",        5'd1, 1, 5'd9, 1, 1, 5'd9, 0, 0, 0, 6'b101000);
    tbl[3] = mk("lu_rs1_noread", 5'd7, 0, 5'd2, 1, 1, 5'd7, 0, 0, 0, 6'b000000);
    tbl[4] = mk("no_load",       5'd7, 1, 5'd7, 1, 0, 5'd7, 0, 0, 0, 6'b000000);
    tbl[5] = mk("br_and_lu",     5'd5, 1, 5'd0, 0, 1, 5'd5, 1, 0, 0, 6'b011000);
    tbl[6] = mk("br_only",       5'd3, 1, 5'd4, 1, 0, 5'd0, 1, 0, 0, 6'b011000);
    tbl[7] = mk("lu_nomatch",    5'd6, 1, 5'd4, 1, 1, 5'd5, 0, 0, 0, 6'b000000);
    tbl[8] = mk("rdy_in_idle",   5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 6'b000000);

    rst_n = 1'b0;
    drive(mk("init", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset outs", {26'd0, if_stop_o, id_flush_o, ex_flush_o, pipe_stop_o, dmem_req_o, err_o}, 32'd0);
    chk("reset stall_cnt", stall_cnt_o, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) step(tbl[i]);

    // memory stall, ready on 3rd WAIT cycle, with branch+hazard held low-priority
    base_cnt = exp_cnt;
    step(mk("mem_detect", 5'd5, 1, 5'd0, 0, 1, 5'd5, 1, 1, 0, 6'b100100));
    step(mk("mem_wait1",  5'd5, 1, 5'd0, 0, 1, 5'd5, 1, 1, 0, 6'b100110));
    step(mk("mem_wait2",  5'd5, 1, 5'd0, 0, 1, 5'd5, 0, 1, 0, 6'b100110));
    step(mk("mem_wait3",  5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 6'b100110));
    step(mk("mem_done",   5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 6'b000000));
    step(mk("mem_idle",   5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 6'b000000));
    chk("mem stall delta", stall_cnt_o - base_cnt, 32'd4);

    // timeout after 4 WAIT cycles, err sticky
    step(mk("to_detect",  5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 6'b100100));
    for (int i = 1; i <= 4; i++)
      step(mk($sformatf("to_wait%0d", i), 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 6'b100110));
    step(mk("to_done",    5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 6'b000001));
    step(mk("to_idle",    5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 6'b000001));
    step(mk("to_lu",      5'd8, 1, 5'd0, 0, 1, 5'd8, 0, 0, 0, 6'b101001));

    // reset pulsed in the middle of WAIT
    step(mk("rs_detect",  5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 6'b100101));
    step(mk("rs_wait1",   5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 6'b100111));
    #2 rst_n = 1'b0;
    #1;
    chk("rst dmem_req", {31'd0, dmem_req_o}, 32'd0);
    chk("rst err", {31'd0, err_o}, 32'd0);
    chk("rst stall_cnt", stall_cnt_o, 32'd0);
    chk("rst comb pipe_stop", {31'd0, pipe_stop_o}, 32'd1);
    @(posedge clk); #1;
    chk("rst no request", {31'd0, dmem_req_o}, 32'd0);
    mem_req_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    step(mk("post_idle",  5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 6'b000000));
    step(mk("post_det",   5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 6'b100100));
    step(mk("post_wait",  5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 6'b100110));
    step(mk("post_done",  5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 6'b000000));
    step(mk("post_end",   5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 6'b000000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
